// File: rtl/mem_arbiter_if.sv
// Client and memory-side signals of the shared 16-bit memory arbiter.
// The arbiter uses the slave modport; the pipeline/memory environment uses master.
interface mem_arbiter_if;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_valid;
    logic        me_req;
    logic        me_wr;
    logic        me_wide;
    logic [31:0] me_addr;
    logic [31:0] me_wdata;
    logic [31:0] me_rdata;
    logic        me_done;
    logic        me_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [15:0] mem_di;
    logic [15:0] mem_do;
    logic        busy;

    modport slave (
        input  flush, if_req, if_addr, me_req, me_wr, me_wide, me_addr, me_wdata, mem_do,
        output if_data, if_valid, me_rdata, me_done, me_err,
               mem_en, mem_wr, mem_addr, mem_di, busy
    );

    modport master (
        output flush, if_req, if_addr, me_req, me_wr, me_wide, me_addr, me_wdata, mem_do,
        input  if_data, if_valid, me_rdata, me_done, me_err,
               mem_en, mem_wr, mem_addr, mem_di, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port 16-bit synchronous-read memory between
// instruction fetch and the data stage. Fetches are always two beats; data
// accesses are one (narrow) or two (wide) beats. Completion pulses are raised
// in the FIN cycle, when the last half arrives on mem_do, and FIN re-arbitrates
// so a new transaction can start with no idle bubble. Requesters are expected
// to drop or replace their request in the cycle they see their pulse.
module mem_arbiter #(
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] ADDR_MAX     = 32'hFFFF0000
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_ME   = 2'd2;

    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    // Control state (reset)
    logic [1:0]    state_q;
    logic [1:0]    owner_q;
    logic          wide_q;
    logic          err_q;
    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_nxt;

    // Transaction payload (no reset; every use is gated by control state)
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          wr_q;
    logic [15:0]   hold_q;

    logic abort;
    logic arb_cycle;
    logic pick_if;
    logic pick_me;
    logic me_bad;
    logic grant_me;
    logic err_set;
    logic fin_if;
    logic fin_me;

    // A flush kills an in-flight fetch; the freed slot is re-arbitrated with
    // fetch excluded so the redirected address is not confused with the old one.
    assign abort     = bus.flush && (owner_q == OWN_IF) && (state_q != ST_IDLE);
    assign arb_cycle = (state_q == ST_IDLE) || (state_q == ST_FIN) || abort;
    assign me_bad    = bus.me_addr > ADDR_MAX;

    // Data has priority unless fetch has waited through LIMIT data grants.
    // While me_err is showing, the failed request is still up, so ignore it.
    assign pick_if  = arb_cycle && !abort && bus.if_req &&
                      (!bus.me_req || err_q || (streak_q == LIMIT));
    assign pick_me  = arb_cycle && bus.me_req && !err_q && !pick_if;
    assign grant_me = pick_me && !me_bad;
    assign err_set  = pick_me && me_bad;

    // Streak of data grants seen while fetch may be waiting; idle time with no fetch clears it.
    always_comb begin
        streak_nxt = streak_q;
        if (pick_if || ((state_q == ST_IDLE) && !bus.if_req)) begin
            streak_nxt = '0;
        end else if (grant_me && (streak_q != LIMIT)) begin
            streak_nxt = streak_q + SW'(1);
        end
    end

    // Beat sequencer, ownership and error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            wide_q   <= 1'b0;
            err_q    <= 1'b0;
            streak_q <= '0;
        end else begin
            err_q    <= err_set;
            streak_q <= streak_nxt;
            if (arb_cycle) begin
                if (grant_me) begin
                    state_q <= ST_BEAT0;
                    owner_q <= OWN_ME;
                    wide_q  <= bus.me_wide;
                end else if (pick_if) begin
                    state_q <= ST_BEAT0;
                    owner_q <= OWN_IF;
                    wide_q  <= 1'b1;
                end else begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                    wide_q  <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_BEAT0: state_q <= wide_q ? ST_BEAT1 : ST_FIN;
                    ST_BEAT1: state_q <= ST_FIN;
                    default:  state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Latch the granted request so a dropped request still completes, and
    // capture the first returned half while the second beat is issued.
    always_ff @(posedge clk) begin
        if (grant_me || pick_if) begin
            addr_q  <= grant_me ? bus.me_addr : bus.if_addr;
            wdata_q <= grant_me ? bus.me_wdata : 32'd0;
            wr_q    <= grant_me && bus.me_wr;
        end
        if (state_q == ST_BEAT1) begin
            hold_q <= bus.mem_do;
        end
    end

    // Memory port: high half first at A, low half at A+1.
    always_comb begin
        bus.mem_addr = 32'd0;
        bus.mem_di   = 16'd0;
        case (state_q)
            ST_BEAT0: begin
                bus.mem_addr = addr_q;
                bus.mem_di   = wide_q ? wdata_q[31:16] : wdata_q[15:0];
            end
            ST_BEAT1: begin
                bus.mem_addr = addr_q + 32'd1;
                bus.mem_di   = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    assign bus.mem_en = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
    assign bus.mem_wr = bus.mem_en && (owner_q == OWN_ME) && wr_q;
    assign bus.busy   = state_q != ST_IDLE;

    assign fin_if = (state_q == ST_FIN) && (owner_q == OWN_IF) && !bus.flush;
    assign fin_me = (state_q == ST_FIN) && (owner_q == OWN_ME);

    // Completion: assemble the word from the held high half and the live low half.
    always_comb begin
        bus.if_data  = 32'd0;
        bus.me_rdata = 32'd0;
        if (fin_if) begin
            bus.if_data = {hold_q, bus.mem_do};
        end
        if (fin_me && !wr_q) begin
            bus.me_rdata = wide_q ? {hold_q, bus.mem_do} : {16'd0, bus.mem_do};
        end
    end

    assign bus.if_valid = fin_if;
    assign bus.me_done  = fin_me;
    assign bus.me_err   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .ADDR_MAX     (32'hFFFF0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 256 words, one-cycle read latency, plus a preload port.
    logic [15:0] mem [0:255];
    logic [15:0] mem_do_r;
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [15:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (bus.mem_en && bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_di;
        if (bus.mem_en) mem_do_r <= mem[bus.mem_addr[7:0]];
    end
    assign bus.mem_do = mem_do_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        logic [9:0]  seq;
        logic [31:0] last_if;
        logic [31:0] last_me;
        int          ev;
        int          npulse;
        logic        overlap;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        bus.flush = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.me_req = 1'b0; bus.me_wr = 1'b0; bus.me_wide = 1'b0;
        bus.me_addr = '0; bus.me_wdata = '0;

        // Reset state
        tick(); tick();
        check("rst_busy",  32'(bus.busy),     32'd0);
        check("rst_en",    32'(bus.mem_en),   32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_done",  32'(bus.me_done),  32'd0);
        check("rst_err",   32'(bus.me_err),   32'd0);
        check("rst_idata", bus.if_data,       32'd0);
        check("rst_rdata", bus.me_rdata,      32'd0);
        rst = 1'b1;
        poke(8'h10, 16'h1234);
        poke(8'h11, 16'h5678);
        poke(8'h30, 16'hBEEF);

        // Fetch: grant, BEAT0, BEAT1, FIN pulse
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick();
        check("f_b0_en",   32'(bus.mem_en), 32'd1);
        check("f_b0_addr", bus.mem_addr,    32'h10);
        check("f_b0_wr",   32'(bus.mem_wr), 32'd0);
        tick();
        check("f_b1_addr", bus.mem_addr,      32'h11);
        check("f_b1_vld",  32'(bus.if_valid), 32'd0);
        tick();
        check("f_valid",   32'(bus.if_valid), 32'd1);
        check("f_data",    bus.if_data,       32'h12345678);
        bus.if_req = 1'b0;
        tick();
        check("f_after_vld",  32'(bus.if_valid), 32'd0);
        check("f_after_busy", 32'(bus.busy),     32'd0);

        // Wide write 0xAABBCCDD at 0x20
        bus.me_req = 1'b1; bus.me_wr = 1'b1; bus.me_wide = 1'b1;
        bus.me_addr = 32'h20; bus.me_wdata = 32'hAABBCCDD;
        tick();
        check("ww_b0_wr", 32'(bus.mem_wr), 32'd1);
        check("ww_b0_di", 32'(bus.mem_di), 32'h0000AABB);
        tick();
        check("ww_b1_addr", bus.mem_addr,    32'h21);
        check("ww_b1_di",   32'(bus.mem_di), 32'h0000CCDD);
        tick();
        check("ww_done",  32'(bus.me_done), 32'd1);
        check("ww_rdata", bus.me_rdata,     32'd0);
        bus.me_req = 1'b0;
        tick();
        check("ww_once", 32'(bus.me_done), 32'd0);
        check("ww_m20",  32'(mem[8'h20]),  32'h0000AABB);
        check("ww_m21",  32'(mem[8'h21]),  32'h0000CCDD);

        // Wide read back of the same word
        bus.me_req = 1'b1; bus.me_wr = 1'b0; bus.me_wide = 1'b1; bus.me_addr = 32'h20;
        tick(); tick(); tick();
        check("wr_done",  32'(bus.me_done), 32'd1);
        check("wr_rdata", bus.me_rdata,     32'hAABBCCDD);
        bus.me_req = 1'b0;
        tick();

        // Narrow read: done two cycles after grant
        bus.me_req = 1'b1; bus.me_wide = 1'b0; bus.me_addr = 32'h30;
        tick();
        check("nr_b0_done", 32'(bus.me_done), 32'd0);
        tick();
        check("nr_done",  32'(bus.me_done), 32'd1);
        check("nr_rdata", bus.me_rdata,     32'h0000BEEF);
        bus.me_req = 1'b0;
        tick();

        // Starvation: both held high -> D D D D F D D D D F
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.me_req = 1'b1; bus.me_wr = 1'b0; bus.me_wide = 1'b0; bus.me_addr = 32'h30;
        seq = '0; ev = 0; overlap = 1'b0; last_if = '0; last_me = '0;
        for (int c = 0; c < 60 && ev < 10; c++) begin
            tick();
            if (bus.if_valid && bus.me_done) overlap = 1'b1;
            if (bus.if_valid) begin
                seq[ev] = 1'b1; ev++; last_if = bus.if_data;
            end else if (bus.me_done) begin
                ev++; last_me = bus.me_rdata;
            end
        end
        bus.if_req = 1'b0; bus.me_req = 1'b0;
        check("st_events",  32'(ev),      32'd10);
        check("st_order",   32'(seq),     32'h00000210);
        check("st_overlap", 32'(overlap), 32'd0);
        check("st_ifdata",  last_if,      32'h12345678);
        check("st_rdata",   last_me,      32'h0000BEEF);
        for (int c = 0; c < 8 && bus.busy; c++) tick();
        check("st_idle", 32'(bus.busy), 32'd0);

        // Flush in BEAT1 of a fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick(); tick();
        bus.flush = 1'b1; bus.if_req = 1'b0;
        npulse = 0;
        tick();
        bus.flush = 1'b0;
        check("fl_busy", 32'(bus.busy),   32'd0);
        check("fl_en",   32'(bus.mem_en), 32'd0);
        for (int c = 0; c < 4; c++) begin
            if (bus.if_valid) npulse++;
            tick();
        end
        check("fl_novalid", 32'(npulse), 32'd0);

        // Flush in the FIN cycle suppresses the pulse
        bus.if_req = 1'b1;
        tick(); tick(); tick();
        bus.flush = 1'b1;
        #1;
        check("flf_valid", 32'(bus.if_valid), 32'd0);
        check("flf_data",  bus.if_data,       32'd0);
        bus.if_req = 1'b0;
        tick();
        bus.flush = 1'b0;
        check("flf_busy", 32'(bus.busy), 32'd0);

        // Flush during a wide write: both halves still land
        bus.me_req = 1'b1; bus.me_wr = 1'b1; bus.me_wide = 1'b1;
        bus.me_addr = 32'h40; bus.me_wdata = 32'h11112222;
        tick();
        bus.flush = 1'b1;
        tick();
        check("flw_b1_en", 32'(bus.mem_en), 32'd1);
        tick();
        check("flw_done", 32'(bus.me_done), 32'd1);
        bus.me_req = 1'b0; bus.flush = 1'b0;
        tick();
        check("flw_m40", 32'(mem[8'h40]), 32'h00001111);
        check("flw_m41", 32'(mem[8'h41]), 32'h00002222);

        // Illegal address: me_err next cycle, no memory access
        bus.me_req = 1'b1; bus.me_wr = 1'b0; bus.me_wide = 1'b0; bus.me_addr = 32'hFFFF0001;
        tick();
        check("er_err",  32'(bus.me_err),  32'd1);
        check("er_en",   32'(bus.mem_en),  32'd0);
        check("er_done", 32'(bus.me_done), 32'd0);
        bus.me_req = 1'b0;
        tick();
        check("er_once", 32'(bus.me_err), 32'd0);
        check("er_en2",  32'(bus.mem_en), 32'd0);

        // Highest legal address is accepted
        bus.me_req = 1'b1; bus.me_addr = 32'hFFFF0000;
        tick();
        check("bd_en",   32'(bus.mem_en), 32'd1);
        check("bd_addr", bus.mem_addr,    32'hFFFF0000);
        check("bd_err",  32'(bus.me_err), 32'd0);
        tick();
        check("bd_done", 32'(bus.me_done), 32'd1);
        bus.me_req = 1'b0;
        tick();

        // Asynchronous reset in BEAT1
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        tick(); tick();
        check("ar_pre_en", 32'(bus.mem_en), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_en",   32'(bus.mem_en), 32'd0);
        check("ar_busy", 32'(bus.busy),   32'd0);
        check("ar_addr", bus.mem_addr,    32'd0);
        bus.if_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("ar_idle",  32'(bus.busy),     32'd0);
        check("ar_valid", 32'(bus.if_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
